mem_stage_access: RTL and testbench

//  MIPS MEM stage, directly downstream of the EX/MEM pipeline register. Consumes its outputs
//  (ALU result, dest reg, RF write controls) plus store data. Runs the data-memory req/ack

---
 rtl/mem_stage_access.sv | 165 ++++++++++++++++
 tb/tb_mem_stage_access.sv | 245 ++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_stage_access.sv
// MIPS MEM stage: data-memory req/ack access, upstream stall, MEM/WB bundle.
// Handshake: mem_req rises on the edge that enters ACCESS and stays high
// (with mem_addr/mem_we/mem_wdata stable) until the edge after a cycle where
// mem_ack=1 or the waitstate counter reaches TIMEOUT. mem_ack is a 1-cycle
// completion strobe and is ignored outside ACCESS. Stall=1 tells upstream
// to hold the EX/MEM register this cycle.
module mem_stage_access #(
  parameter int DATA_W  = 32,
  parameter int REG_W   = 5,
  parameter int TIMEOUT = 15
) (
  input  logic              Clk,
  input  logic              Rst,
  input  logic              in_valid,
  input  logic              RF_WrEn_in,
  input  logic              Mem_Out_sel_in,
  input  logic              RF_WrData_sel_in,
  input  logic              Mem_WrEn_in,
  input  logic [DATA_W-1:0] ALU_out_in,
  input  logic [DATA_W-1:0] Store_data_in,
  input  logic [REG_W-1:0]  instr2016_in,
  output logic              mem_req,
  output logic              mem_we,
  output logic [DATA_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  input  logic              mem_ack,
  output logic              Stall,
  output logic              wb_valid,
  output logic              RF_WrEn_out,
  output logic [REG_W-1:0]  RF_WrAddr_out,
  output logic [DATA_W-1:0] RF_WrData_out,
  output logic              Bus_err,
  output logic              o_dbg_state
);

  localparam int CNT_W = $clog2(TIMEOUT + 1);
  localparam logic [CNT_W-1:0] TO_CNT = CNT_W'(TIMEOUT);

  typedef enum logic {ST_IDLE = 1'b0, ST_ACCESS = 1'b1} state_t;

  state_t            r_state;
  state_t            w_next_state;
  logic [CNT_W-1:0]  r_cnt;
  logic [REG_W-1:0]  r_dest;
  logic              r_wren;
  logic              r_load;
  logic              r_byte;
  logic [1:0]        r_off;

  logic              w_access;
  logic              w_misaligned;
  logic              w_start;
  logic              w_done;
  logic              w_timeout;
  logic [7:0]        w_byte;
  logic [DATA_W-1:0] w_load_data;

  assign o_dbg_state = r_state;

  // State register
  always_ff @(posedge Clk or posedge Rst) begin
    if (Rst) r_state <= ST_IDLE;
    else     r_state <= w_next_state;
  end

  // Next-state: enter ACCESS on an aligned access, leave on ack or timeout
  always_comb begin
    w_next_state = r_state;
    case (r_state)
      ST_IDLE:   if (w_start) w_next_state = ST_ACCESS;
      ST_ACCESS: if (w_done || w_timeout) w_next_state = ST_IDLE;
      default:   w_next_state = ST_IDLE;
    endcase
  end

  // Output decode: access classification, completion events and Stall
  always_comb begin
    w_access     = in_valid & (Mem_WrEn_in | RF_WrData_sel_in);
    w_misaligned = ~Mem_Out_sel_in & (ALU_out_in[1:0] != 2'b00);
    w_start      = (r_state == ST_IDLE) & w_access & ~w_misaligned;
    w_done       = (r_state == ST_ACCESS) & mem_ack;
    // ack has priority over timeout
    w_timeout    = (r_state == ST_ACCESS) & ~mem_ack & (r_cnt == TO_CNT);
    Stall        = ~Rst & (w_start | ((r_state == ST_ACCESS) & ~mem_ack & ~w_timeout));
  end

  // Little-endian byte lane select for zero-extended byte loads
  always_comb begin
    w_byte = 8'h00;
    case (r_off)
      2'd0: w_byte = mem_rdata[7:0];
      2'd1: w_byte = mem_rdata[15:8];
      2'd2: w_byte = mem_rdata[23:16];
      2'd3: w_byte = mem_rdata[31:24];
      default: w_byte = 8'h00;
    endcase
    w_load_data = r_byte ? {{(DATA_W-8){1'b0}}, w_byte} : mem_rdata;
  end

  // Waitstate counter: cleared on entry, counts ACCESS cycles without ack
  always_ff @(posedge Clk or posedge Rst) begin
    if (Rst)                                               r_cnt <= '0;
    else if (w_start)                                      r_cnt <= '0;
    else if ((r_state == ST_ACCESS) && !mem_ack && !w_timeout) r_cnt <= r_cnt + 1'b1;
  end

  // Datapath: memory request, captured bundle and write-back outputs
  always_ff @(posedge Clk or posedge Rst) begin
    if (Rst) begin
      mem_req       <= 1'b0;
      mem_we        <= 1'b0;
      mem_addr      <= '0;
      mem_wdata     <= '0;
      wb_valid      <= 1'b0;
      RF_WrEn_out   <= 1'b0;
      RF_WrAddr_out <= '0;
      RF_WrData_out <= '0;
      Bus_err       <= 1'b0;
      r_dest        <= '0;
      r_wren        <= 1'b0;
      r_load        <= 1'b0;
      r_byte        <= 1'b0;
      r_off         <= 2'b00;
    end else begin
      wb_valid    <= 1'b0;
      RF_WrEn_out <= 1'b0;
      Bus_err     <= 1'b0;
      if (r_state == ST_IDLE) begin
        if (in_valid && !w_access) begin
          wb_valid      <= 1'b1;
          RF_WrEn_out   <= RF_WrEn_in;
          RF_WrAddr_out <= instr2016_in;
          RF_WrData_out <= ALU_out_in;
        end else if (w_access && w_misaligned) begin
          wb_valid <= 1'b1;
          Bus_err  <= 1'b1;
        end else if (w_start) begin
          mem_req   <= 1'b1;
          mem_we    <= Mem_WrEn_in;
          mem_addr  <= {ALU_out_in[DATA_W-1:2], 2'b00};
          mem_wdata <= Store_data_in;
          r_dest    <= instr2016_in;
          r_wren    <= RF_WrEn_in & ~Mem_WrEn_in;
          r_load    <= ~Mem_WrEn_in;
          r_byte    <= Mem_Out_sel_in;
          r_off     <= ALU_out_in[1:0];
        end
      end else begin
        if (w_done) begin
          mem_req       <= 1'b0;
          wb_valid      <= 1'b1;
          RF_WrEn_out   <= r_wren;
          RF_WrAddr_out <= r_dest;
          if (r_load) RF_WrData_out <= w_load_data;
        end else if (w_timeout) begin
          mem_req  <= 1'b0;
          wb_valid <= 1'b1;
          Bus_err  <= 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_mem_stage_access.sv
// Testbench for mem_stage_access: directed instruction sequences, a
// transaction-level model producing per-cycle expectations, one compare
// process at the falling edge, and literal spot checks.
module tb_mem_stage_access;

  localparam int TIMEOUT = 15;

  logic        Clk = 1'b0;
  logic        Rst;
  logic        in_valid, RF_WrEn_in, Mem_Out_sel_in, RF_WrData_sel_in, Mem_WrEn_in;
  logic [31:0] ALU_out_in, Store_data_in, mem_rdata;
  logic [4:0]  instr2016_in;
  logic        mem_ack;
  logic        mem_req, mem_we, Stall, wb_valid, RF_WrEn_out, Bus_err, dbg_state;
  logic [31:0] mem_addr, mem_wdata, RF_WrData_out;
  logic [4:0]  RF_WrAddr_out;

  int checks = 0;
  int failures = 0;
  int stall_cnt = 0;

  typedef struct {
    logic        stall;
    logic        wb_valid;
    logic        wren;
    logic [4:0]  waddr;
    logic [31:0] wdata;
    logic        bus_err;
    logic        req;
    logic        we;
    logic [31:0] maddr;
    logic [31:0] mwdata;
  } exp_t;

  exp_t exp_q[$];

  // model of the registered outputs as they stand after the latest edge
  logic        m_wb_valid, m_wren, m_bus_err, m_req, m_we;
  logic [4:0]  m_waddr;
  logic [31:0] m_wdata, m_maddr, m_mwdata;

  mem_stage_access #(.DATA_W(32), .REG_W(5), .TIMEOUT(TIMEOUT)) dut (
    .Clk(Clk), .Rst(Rst), .in_valid(in_valid), .RF_WrEn_in(RF_WrEn_in),
    .Mem_Out_sel_in(Mem_Out_sel_in), .RF_WrData_sel_in(RF_WrData_sel_in),
    .Mem_WrEn_in(Mem_WrEn_in), .ALU_out_in(ALU_out_in), .Store_data_in(Store_data_in),
    .instr2016_in(instr2016_in), .mem_req(mem_req), .mem_we(mem_we),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata),
    .mem_ack(mem_ack), .Stall(Stall), .wb_valid(wb_valid), .RF_WrEn_out(RF_WrEn_out),
    .RF_WrAddr_out(RF_WrAddr_out), .RF_WrData_out(RF_WrData_out), .Bus_err(Bus_err),
    .o_dbg_state(dbg_state)
  );

  // clock / reset
  always #5 Clk = ~Clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_clear();
    m_wb_valid = 0; m_wren = 0; m_bus_err = 0; m_req = 0; m_we = 0;
    m_waddr = 0; m_wdata = 0; m_maddr = 0; m_mwdata = 0;
  endtask

  // record this cycle's expectations, then advance one edge
  task automatic tick(input logic st);
    exp_t e;
    e.stall = st; e.wb_valid = m_wb_valid; e.wren = m_wren; e.waddr = m_waddr;
    e.wdata = m_wdata; e.bus_err = m_bus_err; e.req = m_req; e.we = m_we;
    e.maddr = m_maddr; e.mwdata = m_mwdata;
    exp_q.push_back(e);
    @(posedge Clk);
    #2;
  endtask

  // driver tasks
  task automatic idle(input logic ack);
    in_valid = 0; mem_ack = ack; mem_rdata = $urandom();
    ALU_out_in = $urandom(); RF_WrData_sel_in = 1; Mem_WrEn_in = 0;
    tick(0);
    m_wb_valid = 0; m_wren = 0; m_bus_err = 0;
  endtask

  task automatic alu_op(input logic wren, input logic [31:0] v, input logic [4:0] rd);
    in_valid = 1; RF_WrEn_in = wren; Mem_WrEn_in = 0; RF_WrData_sel_in = 0;
    Mem_Out_sel_in = $urandom_range(0, 1); ALU_out_in = v; instr2016_in = rd; mem_ack = 0;
    tick(0);
    m_wb_valid = 1; m_wren = wren; m_waddr = rd; m_wdata = v; m_bus_err = 0;
  endtask

  // waits = ACCESS cycles before ack; beyond TIMEOUT means the ack never comes
  task automatic mem_op(input logic st, input logic byt, input logic [31:0] addr,
                        input logic [31:0] sd, input logic [4:0] rd, input int waits,
                        input logic [31:0] rdata);
    in_valid = 1; RF_WrEn_in = 1; Mem_WrEn_in = st; RF_WrData_sel_in = 1;
    Mem_Out_sel_in = byt; ALU_out_in = addr; Store_data_in = sd; instr2016_in = rd;
    mem_ack = 0;
    if (!byt && addr[1:0] != 2'b00) begin
      tick(0);
      m_bus_err = 1; m_wb_valid = 1; m_wren = 0;
    end else begin
      tick(1);
      m_req = 1; m_we = st; m_maddr = {addr[31:2], 2'b00}; m_mwdata = sd;
      m_wb_valid = 0; m_wren = 0; m_bus_err = 0;
      for (int k = 0; k <= TIMEOUT; k++) begin
        in_valid = $urandom_range(0, 1); ALU_out_in = $urandom(); Store_data_in = $urandom();
        instr2016_in = 5'($urandom_range(0, 31)); Mem_WrEn_in = $urandom_range(0, 1);
        Mem_Out_sel_in = $urandom_range(0, 1);
        if (k == waits) begin
          mem_ack = 1; mem_rdata = rdata;
          tick(0);
          m_req = 0; m_wb_valid = 1; m_wren = !st; m_waddr = rd; m_bus_err = 0;
          if (!st) m_wdata = byt ? ((rdata >> (8 * addr[1:0])) & 32'hFF) : rdata;
          break;
        end
        mem_ack = 0; mem_rdata = $urandom();
        if (k == TIMEOUT) begin
          tick(0);
          m_req = 0; m_bus_err = 1; m_wb_valid = 1; m_wren = 0;
        end else begin
          tick(1);
        end
      end
    end
    mem_ack = 0; in_valid = 0;
  endtask

  // scoreboard: compare every cycle against the model's expectations
  always @(negedge Clk) begin
    exp_t e;
    if (!Rst && exp_q.size() > 0) begin
      e = exp_q.pop_front();
      if (Stall) stall_cnt++;
      chk("stall", Stall, e.stall);
      chk("wb_valid", wb_valid, e.wb_valid);
      chk("rf_wren", RF_WrEn_out, e.wren);
      chk("bus_err", Bus_err, e.bus_err);
      chk("mem_req", mem_req, e.req);
      if (e.wren) begin
        chk("rf_waddr", RF_WrAddr_out, e.waddr);
        chk("rf_wdata", RF_WrData_out, e.wdata);
      end
      if (e.req) begin
        chk("mem_we", mem_we, e.we);
        chk("mem_addr", mem_addr, e.maddr);
        chk("mem_wdata", mem_wdata, e.mwdata);
      end
    end
  end

  initial begin
    #100000;
    failures++;
    $display("FAIL watchdog: got timeout expected completion");
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    Rst = 1; in_valid = 0; RF_WrEn_in = 0; Mem_Out_sel_in = 0; RF_WrData_sel_in = 0;
    Mem_WrEn_in = 0; ALU_out_in = 0; Store_data_in = 0; instr2016_in = 0;
    mem_rdata = 0; mem_ack = 0;
    model_clear();
    @(posedge Clk); @(posedge Clk); #2;
    chk("rst_mem_req", mem_req, 0);
    chk("rst_wb_valid", wb_valid, 0);
    chk("rst_bus_err", Bus_err, 0);
    chk("rst_stall", Stall, 0);
    chk("rst_wdata", RF_WrData_out, 0);
    Rst = 0;

    idle(0);
    alu_op(1, 32'h1234, 5);
    chk("alu_wdata", RF_WrData_out, 32'h1234);
    chk("alu_waddr", RF_WrAddr_out, 5);
    chk("alu_wb_valid", wb_valid, 1);
    alu_op(0, 32'h0BAD, 9);
    alu_op(1, 32'hFFFF_0001, 31);
    idle(1);

    stall_cnt = 0;
    mem_op(0, 0, 32'h100, 32'h0, 3, 3, 32'hDEADBEEF);
    chk("ld_word_data", RF_WrData_out, 32'hDEADBEEF);
    chk("ld_word_stall_cycles", stall_cnt, 4);
    idle(0);

    stall_cnt = 0;
    mem_op(0, 1, 32'h103, 32'h0, 4, 0, 32'hAABBCCDD);
    chk("ld_byte_data", RF_WrData_out, 32'h000000AA);
    chk("ld_byte_stall_cycles", stall_cnt, 1);
    mem_op(0, 1, 32'h201, 32'h0, 6, 1, 32'h11223344);
    chk("ld_byte1_data", RF_WrData_out, 32'h00000033);

    mem_op(1, 0, 32'h200, 32'h55, 8, 2, 32'h0);
    chk("st_rf_wren", RF_WrEn_out, 0);
    chk("st_wb_valid", wb_valid, 1);

    mem_op(0, 0, 32'h400, 32'h0, 10, 99, 32'h0);
    chk("to_bus_err", Bus_err, 1);
    chk("to_mem_req", mem_req, 0);
    chk("to_rf_wren", RF_WrEn_out, 0);
    idle(0);
    chk("to_bus_err_drop", Bus_err, 0);
    alu_op(1, 32'hCAFE, 7);
    chk("after_to_wdata", RF_WrData_out, 32'hCAFE);

    mem_op(0, 0, 32'h102, 32'h0, 12, 0, 32'h0);
    chk("misal_bus_err", Bus_err, 1);
    chk("misal_mem_req", mem_req, 0);
    idle(0);

    // reset in the middle of an access
    in_valid = 1; RF_WrEn_in = 1; RF_WrData_sel_in = 1; Mem_WrEn_in = 0;
    Mem_Out_sel_in = 0; ALU_out_in = 32'h300; instr2016_in = 2; mem_ack = 0;
    tick(1);
    m_req = 1; m_we = 0; m_maddr = 32'h300; m_mwdata = Store_data_in;
    m_wb_valid = 0; m_wren = 0; m_bus_err = 0;
    in_valid = 0;
    tick(1);
    chk("pre_rst_mem_req", mem_req, 1);
    Rst = 1;
    #1;
    chk("mid_rst_mem_req", mem_req, 0);
    chk("mid_rst_stall", Stall, 0);
    chk("mid_rst_wdata", RF_WrData_out, 0);
    chk("mid_rst_mem_addr", mem_addr, 0);
    @(posedge Clk); #2;
    Rst = 0;
    exp_q.delete();
    model_clear();
    idle(0);
    alu_op(1, 32'h600D, 1);
    chk("post_rst_wdata", RF_WrData_out, 32'h600D);
    idle(0);
    idle(0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
